// File: rtl/keccak_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keccak_round_ctrl
// Brief    : Round sequencer for the iterative Keccak-f[1600] core
//            (request/complete handshakes, one-hot and binary round index).
// Revision : 1.0 - initial release
// ============================================================================
module keccak_round_ctrl #(
  parameter int ROUNDS = 24,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              load,
  output logic [ROUNDS-1:0] round_onehot,
  output logic [IDX_W-1:0]  round_idx,
  output logic              round_en,
  output logic              round_last,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ROUNDS-1:0] c_round0  = ROUNDS'(1);
  localparam logic [IDX_W-1:0]  c_idx_one = IDX_W'(1);

  state_t            r_state;
  logic [ROUNDS-1:0] r_onehot;
  logic [IDX_W-1:0]  r_idx;

  logic w_onehot_ok;
  logic w_state_ok;
  logic w_accept;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_onehot_ok = (r_onehot != '0) && ((r_onehot & (r_onehot - c_round0)) == '0);
  assign w_state_ok  = (r_state == ST_RUN) ? w_onehot_ok : (r_onehot == '0);

  assign in_ready     = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_accept     = in_valid & in_ready;
  assign load         = w_accept;
  assign out_valid    = (r_state == ST_DONE);
  assign round_en     = (r_state == ST_RUN);
  assign round_last   = round_en & r_onehot[ROUNDS-1];
  assign round_onehot = r_onehot;
  assign round_idx    = r_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_onehot <= '0;
      r_idx    <= '0;
    end else if (!w_state_ok) begin
      r_state  <= ST_IDLE;
      r_onehot <= '0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_RUN;
            r_onehot <= c_round0;
            r_idx    <= '0;
          end
        end
        ST_RUN: begin
          if (r_onehot[ROUNDS-1]) begin
            r_state  <= ST_DONE;
            r_onehot <= '0;
            r_idx    <= '0;
          end else begin
            r_onehot <= r_onehot << 1;
            r_idx    <= r_idx + c_idx_one;
          end
        end
        ST_DONE: begin
          // A pending request restarts directly at round 0 when the result drains.
          if (out_ready) begin
            if (in_valid) begin
              r_state  <= ST_RUN;
              r_onehot <= c_round0;
              r_idx    <= '0;
            end else begin
              r_state  <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_onehot <= '0;
          r_idx    <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keccak_round_ctrl.sv
`default_nettype none
// Testbench for keccak_round_ctrl: directed requests with queued expectations
// checked by an independent monitor on every falling clock edge.
module tb_keccak_round_ctrl;

  localparam int ROUNDS = 24;
  localparam int IDX_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              load;
  logic [ROUNDS-1:0] round_onehot;
  logic [IDX_W-1:0]  round_idx;
  logic              round_en;
  logic              round_last;
  logic              out_valid;
  logic              out_ready;

  keccak_round_ctrl #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .load         (load),
    .round_onehot (round_onehot),
    .round_idx    (round_idx),
    .round_en     (round_en),
    .round_last   (round_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int idx;
  } round_exp_t;

  int         exp_load[$];
  round_exp_t exp_round[$];
  int         exp_valid[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Expected responses for a request accepted in cycle t whose result is held
  // for 'hold' extra cycles of backpressure.
  task automatic expect_perm(input int t, input int hold);
    round_exp_t e;
    exp_load.push_back(t);
    for (int k = 0; k < ROUNDS; k++) begin
      e.cyc = t + 1 + k;
      e.idx = k;
      exp_round.push_back(e);
    end
    for (int h = 0; h <= hold; h++) exp_valid.push_back(t + 1 + ROUNDS + h);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops and compares whenever an expectation is due or the DUT presents output.
  always @(negedge clk) begin
    logic [ROUNDS-1:0] eoh;
    if (exp_load.size() > 0 && exp_load[0] == cyc) begin
      chk("load", 32'(load), 32'd1);
      void'(exp_load.pop_front());
    end else if (load) begin
      chk("unexpected_load", 32'(load), 32'd0);
    end

    if (exp_round.size() > 0 && exp_round[0].cyc == cyc) begin
      eoh = ROUNDS'(1) << exp_round[0].idx;
      chk("round_en", 32'(round_en), 32'd1);
      chk("round_idx", 32'(round_idx), 32'(exp_round[0].idx));
      chk("round_onehot", 32'(round_onehot), 32'(eoh));
      chk("round_last", 32'(round_last), (exp_round[0].idx == ROUNDS - 1) ? 32'd1 : 32'd0);
      void'(exp_round.pop_front());
    end else if (round_en) begin
      chk("unexpected_round_en", 32'(round_en), 32'd0);
    end else begin
      chk("idle_onehot", 32'(round_onehot), 32'd0);
    end

    if (exp_valid.size() > 0 && exp_valid[0] == cyc) begin
      chk("out_valid", 32'(out_valid), 32'd1);
      void'(exp_valid.pop_front());
    end else if (out_valid) begin
      chk("unexpected_out_valid", 32'(out_valid), 32'd0);
    end
  end

  initial begin
    int t;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset and idle
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_onehot", 32'(round_onehot), 32'd0);
    chk("rst_idx", 32'(round_idx), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_round_en", 32'(round_en), 32'd0);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
    end

    // Single permutation
    tick();
    t = cyc;
    in_valid = 1'b1;
    expect_perm(t, 0);
    tick();
    in_valid = 1'b0;
    while (cyc < t + ROUNDS + 2) tick();
    @(negedge clk);
    chk("single_back_idle", 32'(in_ready), 32'd1);

    // Output backpressure with in_valid held throughout
    tick();
    t = cyc;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    expect_perm(t, 10);
    expect_perm(t + ROUNDS + 11, 0);
    while (cyc < t + ROUNDS + 1) tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_load", 32'(load), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_restart_onehot", 32'(round_onehot), 32'd1);
    while (cyc < t + 2 * ROUNDS + 14) tick();

    // Back-to-back with both handshakes held high
    tick();
    t = cyc;
    in_valid = 1'b1;
    for (int p = 0; p < 3; p++) expect_perm(t + p * (ROUNDS + 1), 0);
    while (cyc < t + 2 * (ROUNDS + 1)) tick();
    tick();
    in_valid = 1'b0;
    while (cyc < t + 3 * (ROUNDS + 1) + 2) tick();

    // Request during round 10 is ignored
    tick();
    t = cyc;
    in_valid = 1'b1;
    expect_perm(t, 0);
    tick();
    in_valid = 1'b0;
    while (cyc < t + 11) tick();
    in_valid = 1'b1;
    @(negedge clk);
    chk("ign_in_ready", 32'(in_ready), 32'd0);
    chk("ign_idx", 32'(round_idx), 32'd10);
    tick();
    in_valid = 1'b0;
    while (cyc < t + ROUNDS + 3) tick();

    // Reset during round 12
    tick();
    t = cyc;
    in_valid = 1'b1;
    expect_perm(t, 0);
    tick();
    in_valid = 1'b0;
    while (cyc < t + 13) tick();
    @(negedge clk);
    #1;
    reset = 1'b0;
    exp_round.delete();
    exp_valid.delete();
    #1;
    chk("mid_rst_onehot", 32'(round_onehot), 32'd0);
    chk("mid_rst_round_en", 32'(round_en), 32'd0);
    chk("mid_rst_idx", 32'(round_idx), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    repeat (30) tick();
    t = cyc;
    in_valid = 1'b1;
    expect_perm(t, 0);
    tick();
    in_valid = 1'b0;
    while (cyc < t + ROUNDS + 3) tick();

    @(negedge clk);
    chk("pending_load", 32'(exp_load.size()), 32'd0);
    chk("pending_round", 32'(exp_round.size()), 32'd0);
    chk("pending_valid", 32'(exp_valid.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
